// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver (configurable data/parity/stop) feeding a
// first-word fall-through receive FIFO with RTS flow control output.
//
// Ports:
//   clock          system clock, rising edge
//   reset          asynchronous, active-high reset
//   uart_rx        asynchronous serial input, idles high
//   rx_ready       consumer accepts head word this cycle
//   rx_valid       FIFO non-empty, head word presented
//   rx_data        head word data (LSB = first received bit), 0 when empty
//   rx_parity_err  parity error flag of head word, 0 when empty
//   rx_frame_err   framing error flag of head word, 0 when empty
//   rx_overrun     one-cycle pulse when a completed word is dropped
//   rts            high = room for more frames (registered)
//   fifo_count     current FIFO occupancy
module uart_rx_fifo #(
   parameter int CLKS_PER_BIT = 54,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4,
   parameter int RTS_THRESH   = FIFO_DEPTH - 1
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          uart_rx,
   input  logic                          rx_ready,
   output logic                          rx_valid,
   output logic [DATA_BITS-1:0]          rx_data,
   output logic                          rx_parity_err,
   output logic                          rx_frame_err,
   output logic                          rx_overrun,
   output logic                          rts,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int WW = DATA_BITS + 2;

   localparam logic [15:0] HALF_C = 16'(CLKS_PER_BIT / 2 - 1);
   localparam logic [15:0] FULL_C = 16'(CLKS_PER_BIT - 1);
   localparam logic [3:0]  LAST_BIT = 4'(DATA_BITS - 1);
   localparam logic        LAST_STOP = 1'(STOP_BITS - 1);
   localparam logic        ODD_PAR = (PARITY == 2);
   localparam logic        HAS_PAR = (PARITY != 0);
   localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);
   localparam logic [AW:0] RTS_C = (AW + 1)'(RTS_THRESH);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;
   localparam logic [2:0] ST_BREAK  = 3'd5;

   // synchronizer
   logic rx_meta;
   logic rxs;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= uart_rx;
         rxs     <= rx_meta;
      end
   end

   // receiver FSM
   logic [2:0]           state;
   logic [15:0]          cnt;
   logic [3:0]           bit_idx;
   logic                 stop_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_err;
   logic                 frm_err;

   logic                 at_full;
   logic                 push_en;
   logic [WW-1:0]        push_word;

   assign at_full = (cnt == FULL_C);

   // the last stop sample pushes in the same edge it is taken, so the
   // word folds in the current sample rather than the registered flag
   assign push_en = (state == ST_STOP) && at_full
                    && (stop_idx == LAST_STOP);
   assign push_word = {par_err, frm_err | ~rxs, shreg};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         bit_idx  <= '0;
         stop_idx <= 1'b0;
         shreg    <= '0;
         par_err  <= 1'b0;
         frm_err  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!rxs) begin
                  state <= ST_START;
                  cnt   <= '0;
               end
            end
            ST_START: begin
               if (cnt == HALF_C) begin
                  cnt <= '0;
                  if (rxs) begin
                     state <= ST_IDLE;
                  end else begin
                     state    <= ST_DATA;
                     bit_idx  <= '0;
                     stop_idx <= 1'b0;
                     par_err  <= 1'b0;
                     frm_err  <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            ST_DATA: begin
               if (at_full) begin
                  cnt     <= '0;
                  shreg   <= {rxs, shreg[DATA_BITS-1:1]};
                  bit_idx <= bit_idx + 4'd1;
                  if (bit_idx == LAST_BIT)
                     state <= HAS_PAR ? ST_PARITY : ST_STOP;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            ST_PARITY: begin
               if (at_full) begin
                  cnt     <= '0;
                  par_err <= (^shreg) ^ rxs ^ ODD_PAR;
                  state   <= ST_STOP;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            ST_STOP: begin
               if (at_full) begin
                  cnt <= '0;
                  if (!rxs)
                     frm_err <= 1'b1;
                  if (stop_idx == LAST_STOP)
                     state <= rxs ? ST_IDLE : ST_BREAK;
                  else
                     stop_idx <= stop_idx + 1'b1;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            ST_BREAK: begin
               // a held-low line must not start a new frame
               if (rxs)
                  state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // receive FIFO
   logic [WW-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [WW-1:0] head;
   logic          full;
   logic          do_pop;
   logic          do_push;

   assign full     = (fifo_count == DEPTH_C);
   assign rx_valid = (fifo_count != '0);
   assign do_pop   = rx_valid & rx_ready;
   // a same-cycle pop frees the slot, so a push into a full FIFO is kept
   assign do_push  = push_en & (~full | do_pop);

   assign head          = mem[rptr];
   assign rx_data       = rx_valid ? head[DATA_BITS-1:0] : '0;
   assign rx_frame_err  = rx_valid & head[DATA_BITS];
   assign rx_parity_err = rx_valid & head[DATA_BITS+1];

   always_ff @(posedge clock) begin
      if (do_push)
         mem[wptr] <= push_word;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wptr       <= '0;
         rptr       <= '0;
         fifo_count <= '0;
         rx_overrun <= 1'b0;
         rts        <= 1'b1;
      end else begin
         if (do_push)
            wptr <= wptr + 1'b1;
         if (do_pop)
            rptr <= rptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
         rx_overrun <= push_en & full & ~do_pop;
         rts        <= (fifo_count < RTS_C);
      end
   end

endmodule
